scroll_display_driver: RTL and testbench
========================================

Name: scroll_display_driver

Overview:
- Downstream consumer of the 4-bit scroll address produced by the rotating address counter.
- Treats addr as the base index into a 16-entry character memory and shows 4 consecutive characters (addr..addr+3, mod 16) on the board's 4-digit multiplexed 7-segment display.
- Owns digit-multiplexing timing, anti-ghosting blanking, segment decoding and frame-boundary signalling.

Parameters:
- REFRESH_DIV, 4096, clk cycles per digit slot. Constraint: REFRESH_DIV >= BLANK_CYCLES + 2.
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off. Constraint: BLANK_CYCLES >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- addr  input  4  scroll base address from the upstream rotation counter
- an  output  4  digit anodes, active-low; an[3] = leftmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - slot counter cnt=0, digit index d=0, base register=0
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0
- All outputs are registered.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, d advances 0->1->2->3->0.
  - d=0 drives an[3], d=1 an[2], d=2 an[1], d=3 an[0].
- Blanking and anode drive:
  - While cnt < BLANK_CYCLES, an=4'b1111.
  - Otherwise only the anode for d is driven low.
  - An anode is never low during the first BLANK_CYCLES cycles of a slot.
- Character fetch:
  - Character index = (base + d) mod 16, 4-bit wrap-around. Example: base=14 shows E,F,0,1.
  - The character memory is an internal 16x4 ROM with entry k = k, so the display reads base..base+3 in hex.
- Segment update:
  - seg is loaded on the cycle cnt wraps to 0, i.e. inside the blank window, so it is stable before its anode turns on.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp = 1 (off) always, unless the optional feature is enabled.
- frame_tick = 1 for exactly the cycle where d=3 and cnt=REFRESH_DIV-1; 0 otherwise.
- Base register behaviour is set by FRAME_LATCH_EN (see Optional Feature).
- Reset mid-slot: all outputs return to reset values immediately; counting restarts at cnt=0, d=0 after deassertion. The first anode goes low BLANK_CYCLES cycles after deassertion.
- addr changing mid-slot never alters seg within the current slot, because seg only loads at the slot boundary.

Optional Feature:
- Macro FRAME_LATCH_EN.
- Defined:
  - base samples addr only at frame start (the cycle cnt wraps with d going 3->0) and once on reset release.
  - A scroll step becomes visible as a whole frame; no tearing.
- Undefined:
  - base follows addr every cycle.
  - A mid-frame addr change is visible from the next slot, so a frame may mix two bases.

Test Plan (REFRESH_DIV=16, BLANK_CYCLES=4):
- Reset held, addr=5 -> an=1111, seg=1111111, dp=1, frame_tick=0. Release -> an=0111 first appears 4 cycles later, with seg=0010010 (5).
- addr=14 constant for 2 frames -> slots show E(0000110), F(0001110), 0(1000000), 1(1111001) on an=0111, 1011, 1101, 1110.
- Any slot -> an=1111 for the first 4 cycles of every slot; never two anodes low at once.
- frame_tick check -> single-cycle pulse every 64 cycles, coincident with d=3 and cnt=15.
- FRAME_LATCH_EN defined, addr 2->3 during d=1 -> rest of the frame shows 3,4,5 (base 2); next frame shows 3,4,5,6.
- FRAME_LATCH_EN undefined, same stimulus -> d=2 slot shows 5 (base 3).
- Reset asserted during d=2, cnt=9 -> outputs go to reset values in the same cycle; sequence restarts at d=0.

Source files
------------

// File: rtl/scroll_display_driver_if.sv
// Display-side bundle for scroll_display_driver: scroll address in, digit/segment drive out.
interface scroll_display_driver_if;
    logic [3:0] addr;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        input  addr,
        output an,
        output seg,
        output dp,
        output frame_tick
    );

    modport slave (
        output addr,
        input  an,
        input  seg,
        input  dp,
        input  frame_tick
    );
endinterface

// File: rtl/scroll_display_driver.sv
// Multiplexed 4-digit 7-segment driver showing addr..addr+3 (hex) with blanking and frame ticks.
// Define FRAME_LATCH_EN to latch the scroll base once per frame instead of tracking addr every cycle.
module scroll_display_driver #(
    parameter int unsigned REFRESH_DIV  = 4096,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    scroll_display_driver_if.master  bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    if ((REFRESH_DIV < BLANK_CYCLES + 2) || (BLANK_CYCLES < 1)) begin : g_param_check
        $error("scroll_display_driver: need BLANK_CYCLES >= 1 and REFRESH_DIV >= BLANK_CYCLES + 2");
    end

    localparam logic [3:0] CHAR_ROM [16] = '{
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] ch);
        logic [6:0] s;
        case (ch)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       d_q, d_nxt;
    logic             primed_q;
    logic [3:0]       an_q, an_nxt;
    logic [6:0]       seg_q, seg_nxt;
    logic             dp_q;
    logic             frame_tick_q, frame_tick_nxt;
    logic             wrap, frame_start, load_seg;
    logic [3:0]       base_nxt;
    logic [3:0]       char_idx;

    // Slot timing, computed one cycle ahead so every output flop lines up with cnt/d.
    always_comb begin
        cnt_nxt        = cnt_q + CNT_W'(1);
        d_nxt          = d_q;
        if (cnt_q == CNT_LAST) begin
            cnt_nxt = '0;
            d_nxt   = d_q + 2'd1;
        end
        wrap           = (cnt_nxt == '0);
        frame_start    = wrap && (d_nxt == 2'd0);
        // The first cycle out of reset is not a wrap, but the first slot still needs its digit.
        load_seg       = wrap || !primed_q;
        frame_tick_nxt = (d_nxt == 2'd3) && (cnt_nxt == CNT_LAST);
        an_nxt         = 4'b1111;
        if (cnt_nxt >= CNT_BLANK) begin
            an_nxt[2'd3 - d_nxt] = 1'b0;
        end
    end

`ifdef FRAME_LATCH_EN
    logic [3:0] base_q;

    // Base only moves at frame start (or reset release) so a frame never mixes two bases.
    always_comb begin
        base_nxt = base_q;
        if (frame_start || !primed_q) begin
            base_nxt = bus.addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= 4'd0;
        end else begin
            base_q <= base_nxt;
        end
    end
`else
    logic unused_frame_start;

    always_comb begin
        base_nxt           = bus.addr;
        unused_frame_start = frame_start;
    end
`endif

    // Character fetch and decode for the slot about to start.
    always_comb begin
        char_idx = base_nxt + {2'b00, d_nxt};
        seg_nxt  = seg_q;
        if (load_seg) begin
            seg_nxt = seg_decode(CHAR_ROM[char_idx]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            d_q          <= 2'd0;
            primed_q     <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_nxt;
            d_q          <= d_nxt;
            primed_q     <= 1'b1;
            an_q         <= an_nxt;
            seg_q        <= seg_nxt;
            dp_q         <= 1'b1;
            frame_tick_q <= frame_tick_nxt;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scroll_display_driver.sv
// Directed bench for scroll_display_driver with REFRESH_DIV=16, BLANK_CYCLES=4.
module tb_scroll_display_driver;

    localparam int unsigned RDIV  = 16;
    localparam int unsigned BLANK = 4;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] AN_D [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef struct {
        logic [3:0] addr;
        int         d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    scroll_display_driver_if bus ();

    scroll_display_driver #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic e_ft);
        checks++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_ft}) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                     name, bus.an, bus.seg, bus.dp, bus.frame_tick, e_an, e_seg, e_dp, e_ft);
        end
    endtask

    // Step through cycles first..last of slot d, checking every cycle; optional mid-slot addr change.
    task automatic run_slot(input int d, input int first, input int last, input logic [6:0] e_seg,
                            input int chg_at, input logic [3:0] chg_val);
        for (int c = first; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("slot d%0d cnt%0d", d, c),
                  (c < int'(BLANK)) ? 4'b1111 : AN_D[d], e_seg, 1'b1,
                  (d == 3) && (c == int'(RDIV) - 1));
            if (c == chg_at) bus.addr = chg_val;
        end
    endtask

    task automatic add_frame(input logic [3:0] a, input int c0, input int c1, input int c2, input int c3);
        vecs.push_back('{a, 0, AN_D[0], SEG[c0]});
        vecs.push_back('{a, 1, AN_D[1], SEG[c1]});
        vecs.push_back('{a, 2, AN_D[2], SEG[c2]});
        vecs.push_back('{a, 3, AN_D[3], SEG[c3]});
    endtask

    initial begin
        int lat_d2, lat_d3;
        // Expected digits per frame, hand-computed as base..base+3 mod 16
        add_frame(4'd14, 14, 15, 0, 1);
        add_frame(4'd14, 14, 15, 0, 1);
        add_frame(4'd0,  0, 1, 2, 3);
        add_frame(4'd3,  3, 4, 5, 6);
        add_frame(4'd5,  5, 6, 7, 8);
        add_frame(4'd9,  9, 10, 11, 12);
        add_frame(4'd13, 13, 14, 15, 0);

        reset    = 1'b1;
        bus.addr = 4'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset held", 4'b1111, 7'b1111111, 1'b1, 1'b0);

        // Release: digit 5 loads immediately, anode stays dark for BLANK cycles
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("release cyc%0d", i), (i < 4) ? 4'b1111 : 4'b0111, SEG[5], 1'b1, 1'b0);
        end
        repeat (59) @(posedge clk);
        @(negedge clk);

        // Table-driven frames, each slot checked cycle by cycle
        foreach (vecs[i]) begin
            bus.addr = vecs[i].addr;
            for (int c = 0; c < int'(RDIV); c++) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("vec%0d cnt%0d", i, c),
                      (c < int'(BLANK)) ? 4'b1111 : vecs[i].exp_an, vecs[i].exp_seg, 1'b1,
                      (vecs[i].d == 3) && (c == int'(RDIV) - 1));
            end
        end

        // addr 2->3 in the middle of slot d=1
`ifdef FRAME_LATCH_EN
        lat_d2 = 4;
        lat_d3 = 5;
`else
        lat_d2 = 5;
        lat_d3 = 6;
`endif
        bus.addr = 4'd2;
        run_slot(0, 0, 15, SEG[2], -1, 4'd0);
        run_slot(1, 0, 15, SEG[3], 8, 4'd3);
        run_slot(2, 0, 15, SEG[lat_d2], -1, 4'd0);
        run_slot(3, 0, 15, SEG[lat_d3], -1, 4'd0);
        run_slot(0, 0, 15, SEG[3], -1, 4'd0);
        run_slot(1, 0, 15, SEG[4], -1, 4'd0);
        run_slot(2, 0, 15, SEG[5], -1, 4'd0);
        run_slot(3, 0, 15, SEG[6], -1, 4'd0);

        // Reset at d=2, cnt=9: outputs clear without a clock, then restart from d=0
        run_slot(0, 0, 15, SEG[3], -1, 4'd0);
        run_slot(1, 0, 15, SEG[4], -1, 4'd0);
        run_slot(2, 0, 9, SEG[5], -1, 4'd0);
        reset = 1'b1;
        #1;
        check("async reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("reset hold", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        reset = 1'b0;
        run_slot(0, 1, 15, SEG[3], -1, 4'd0);
        run_slot(1, 0, 15, SEG[4], -1, 4'd0);
        run_slot(2, 0, 15, SEG[5], -1, 4'd0);
        run_slot(3, 0, 15, SEG[6], -1, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
